frame_commit_ctrl: RTL

- Frame-synchronous commit controller between the SPI frontend's live polygon/background registers and the rasterizer.
- Holds an active (shadow) copy of all scene state and gates the frontend load window (en_load). The rasterizer only sees scene changes at vertical-blank boundaries, so a frame never tears mid-scan.
- Adds a freeze control and frame/deferral statistics for the host.

---
 rtl/frame_commit_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/frame_commit_ctrl.sv
// Frame-synchronous commit of live SPI scene registers into the active copy
// the rasterizer reads; commits only in vblank (or while the display is off).

module fcc_poly_cmp #(
    parameter int LW = 8
) (
    input  logic [LW-1:0] live_lane,
    input  logic [LW-1:0] act_lane,
    output logic          diff
);
    assign diff = |(live_lane ^ act_lane);
endmodule

module frame_commit_ctrl #(
    parameter int N_POLY = 4,
    parameter int WCOLOR = 6,
    parameter int WPX    = 7,
    parameter int WPY    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     hblank,
    input  logic                     display_on,
    input  logic                     freeze,
    input  logic [WCOLOR-1:0]        live_bg_color,
    input  logic [WCOLOR*N_POLY-1:0] live_poly_color,
    input  logic [WPX*N_POLY-1:0]    live_v0_x,
    input  logic [WPX*N_POLY-1:0]    live_v1_x,
    input  logic [WPX*N_POLY-1:0]    live_v2_x,
    input  logic [WPY*N_POLY-1:0]    live_v0_y,
    input  logic [WPY*N_POLY-1:0]    live_v1_y,
    input  logic [WPY*N_POLY-1:0]    live_v2_y,
    input  logic [N_POLY-1:0]        live_poly_en,
    output logic [WCOLOR-1:0]        act_bg_color,
    output logic [WCOLOR*N_POLY-1:0] act_poly_color,
    output logic [WPX*N_POLY-1:0]    act_v0_x,
    output logic [WPX*N_POLY-1:0]    act_v1_x,
    output logic [WPX*N_POLY-1:0]    act_v2_x,
    output logic [WPY*N_POLY-1:0]    act_v0_y,
    output logic [WPY*N_POLY-1:0]    act_v1_y,
    output logic [WPY*N_POLY-1:0]    act_v2_y,
    output logic [N_POLY-1:0]        act_poly_en,
    output logic                     en_load,
    output logic                     pending,
    output logic                     commit_pulse,
    output logic [7:0]               frame_count,
    output logic [7:0]               defer_count
);
    localparam int LW = WCOLOR + 3*WPX + 3*WPY + 1;
    localparam int SW = WCOLOR + N_POLY*LW;

    typedef enum logic [1:0] {IDLE, PENDING, COMMITTED} state_t;

    state_t state_q, state_d;
    logic [SW-1:0] live_vec, act_q;
    logic [N_POLY-1:0][LW-1:0] live_lane, act_lane;
    logic [N_POLY-1:0] lane_diff;
    logic mismatch, commit_cond;

    assign live_vec = {live_bg_color, live_poly_color, live_v0_x, live_v1_x, live_v2_x,
                       live_v0_y, live_v1_y, live_v2_y, live_poly_en};
    assign {act_bg_color, act_poly_color, act_v0_x, act_v1_x, act_v2_x,
            act_v0_y, act_v1_y, act_v2_y, act_poly_en} = act_q;

    // Per-polygon comparators; each lane gathers one polygon's fields.
    for (genvar i = 0; i < N_POLY; i++) begin : g_lane
        assign live_lane[i] = {live_poly_color[i*WCOLOR +: WCOLOR],
                               live_v0_x[i*WPX +: WPX], live_v1_x[i*WPX +: WPX],
                               live_v2_x[i*WPX +: WPX], live_v0_y[i*WPY +: WPY],
                               live_v1_y[i*WPY +: WPY], live_v2_y[i*WPY +: WPY],
                               live_poly_en[i]};
        assign act_lane[i]  = {act_poly_color[i*WCOLOR +: WCOLOR],
                               act_v0_x[i*WPX +: WPX], act_v1_x[i*WPX +: WPX],
                               act_v2_x[i*WPX +: WPX], act_v0_y[i*WPY +: WPY],
                               act_v1_y[i*WPY +: WPY], act_v2_y[i*WPY +: WPY],
                               act_poly_en[i]};
        fcc_poly_cmp #(.LW(LW)) u_cmp (
            .live_lane (live_lane[i]),
            .act_lane  (act_lane[i]),
            .diff      (lane_diff[i])
        );
    end

    assign mismatch    = (|lane_diff) | (live_bg_color != act_bg_color);
    assign commit_cond = mismatch & ~freeze & (frame_start | ~display_on);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            act_q       <= '0;
            en_load     <= 1'b0;
            frame_count <= 8'd0;
            defer_count <= 8'd0;
        end else begin
            state_q <= state_d;
            if (commit_cond)
                act_q <= live_vec;
            en_load <= ~display_on | hblank;
            if (frame_start)
                frame_count <= frame_count + 8'd1;
            if (frame_start && mismatch && freeze && defer_count != 8'hFF)
                defer_count <= defer_count + 8'd1;
        end
    end

    // Every state, COMMITTED included, re-evaluates the same commit rule.
    always_comb begin
        state_d      = IDLE;
        pending      = 1'b0;
        commit_pulse = 1'b0;
        if (commit_cond)
            state_d = COMMITTED;
        else if (mismatch)
            state_d = PENDING;
        case (state_q)
            PENDING:   pending      = 1'b1;
            COMMITTED: commit_pulse = 1'b1;
            default:   ;
        endcase
    end
endmodule
